// File: rtl/id_track_pkg.sv
// Shared widths and the per-entry record for the AXI ID tracking table.
package id_track_pkg;

    localparam int unsigned IdCapacity  = 16;
    localparam int unsigned IdWidth     = 4;
    localparam int unsigned MaxTxnPerId = 8;
    localparam int unsigned CntWidth    = 10;
    localparam int unsigned TxnCntWidth = $clog2(MaxTxnPerId + 1);
    localparam int unsigned IdxWidth    = (IdCapacity > 1) ? $clog2(IdCapacity) : 1;

    typedef struct packed {
        logic                   free;
        logic [IdWidth-1:0]     id;
        logic [TxnCntWidth-1:0] txn_cnt;
        logic [CntWidth-1:0]    timer;
    } id_track_t;

    // Value every entry takes on reset: free, no ID, idle timer.
    function automatic id_track_t entry_reset();
        id_track_t e;
        e         = '0;
        e.free    = 1'b1;
        return e;
    endfunction

endpackage

// File: rtl/id_free.sv
// Extracts the per-entry free bits from the tracking table.
module id_free #(
    parameter int unsigned IdCapacity = 16,
    parameter type         id_track_t = id_track_pkg::id_track_t
) (
    input  id_track_t [IdCapacity-1:0] id_track_i,
    output logic      [IdCapacity-1:0] id_free_o
);

    // One free bit per table entry.
    always_comb begin
        id_free_o = '0;
        for (int i = 0; i < int'(IdCapacity); i++) begin
            id_free_o[i] = id_track_i[i].free;
        end
    end

endmodule

// File: rtl/lzc.sv
// Leading/trailing zero counter. MODE=0 returns the index of the lowest set
// bit (trailing zeros); MODE=1 returns the number of leading zeros.
module lzc #(
    parameter int unsigned WIDTH     = 2,
    parameter bit          MODE      = 1'b0,
    parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0]     in_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 empty_o
);

    // Scan so that the last hit written is the one the mode asks for.
    always_comb begin
        cnt_o   = '0;
        empty_o = 1'b1;
        if (MODE == 1'b0) begin
            for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
                if (in_i[i]) begin
                    cnt_o   = CNT_WIDTH'(i);
                    empty_o = 1'b0;
                end
            end
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (in_i[i]) begin
                    cnt_o   = CNT_WIDTH'(int'(WIDTH) - 1 - i);
                    empty_o = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/id_track_alloc.sv
// Per-ID tracking table: joins or claims entries on requests, retires on
// last-beat responses, and runs a budget timer per busy entry.
module id_track_alloc
    import id_track_pkg::*;
(
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [IdWidth-1:0]         req_id_i,
    input  logic                       rsp_valid_i,
    output logic                       rsp_ready_o,
    input  logic [IdWidth-1:0]         rsp_id_i,
    input  logic                       rsp_last_i,
    input  logic [CntWidth-1:0]        budget_i,
    output id_track_t [IdCapacity-1:0] id_track_o,
    output logic [IdCapacity-1:0]      id_free_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [IdCapacity-1:0]      timeout_o,
    output logic                       unexpected_rsp_o
);

    id_track_t [IdCapacity-1:0] entry_q, entry_d;
    logic [IdCapacity-1:0]      timeout_q, timeout_d;
    logic                       unexpected_q, unexpected_d;

    logic [IdCapacity-1:0]      req_match, rsp_match;
    logic                       req_hit, req_fire, rsp_act;
    logic [TxnCntWidth-1:0]     hit_cnt;
    logic [IdxWidth-1:0]        alloc_idx;
    logic                       alloc_none;

    assign id_track_o       = entry_q;
    assign timeout_o        = timeout_q;
    assign unexpected_rsp_o = unexpected_q;
    assign rsp_ready_o      = 1'b1;

    id_free #(
        .IdCapacity (IdCapacity),
        .id_track_t (id_track_t)
    ) u_id_free (
        .id_track_i (entry_q),
        .id_free_o  (id_free_o)
    );

    assign full_o  = ~|id_free_o;
    assign empty_o = &id_free_o;

    // Lowest free index comes from the registered free vector, so an entry
    // freed this cycle is not reusable until the next one.
    lzc #(
        .WIDTH     (IdCapacity),
        .MODE      (1'b0),
        .CNT_WIDTH (IdxWidth)
    ) u_lzc (
        .in_i    (id_free_o),
        .cnt_o   (alloc_idx),
        .empty_o (alloc_none)
    );

    // ID match against busy entries; the matched count is OR-reduced since
    // at most one entry can hold a given ID.
    always_comb begin
        req_match = '0;
        rsp_match = '0;
        hit_cnt   = '0;
        for (int i = 0; i < int'(IdCapacity); i++) begin
            req_match[i] = !entry_q[i].free && (entry_q[i].id == req_id_i);
            rsp_match[i] = !entry_q[i].free && (entry_q[i].id == rsp_id_i);
            if (req_match[i]) begin
                hit_cnt = hit_cnt | entry_q[i].txn_cnt;
            end
        end
    end

    assign req_hit      = |req_match;
    assign req_ready_o  = req_hit ? (hit_cnt < TxnCntWidth'(MaxTxnPerId)) : !full_o;
    assign req_fire     = req_valid_i && req_ready_o;
    assign rsp_act      = rsp_valid_i && rsp_last_i;
    assign unexpected_d = rsp_act && !(|rsp_match);

    for (genvar g = 0; g < int'(IdCapacity); g++) begin : g_entry
        logic      claim, incr, decr;
        id_track_t nxt;
        logic      to_nxt;

        assign claim = req_fire && !req_hit && !alloc_none && (alloc_idx == IdxWidth'(g));
        assign incr  = req_fire && req_match[g];
        assign decr  = rsp_act && rsp_match[g];

        // Entry next state: claim, retire, join, or let the timer run.
        always_comb begin
            nxt    = entry_q[g];
            to_nxt = 1'b0;
            if (claim) begin
                nxt.free    = 1'b0;
                nxt.id      = req_id_i;
                nxt.txn_cnt = TxnCntWidth'(1);
                nxt.timer   = budget_i;
            end else if (decr && !incr && (entry_q[g].txn_cnt == TxnCntWidth'(1))) begin
                nxt.free    = 1'b1;
                nxt.txn_cnt = '0;
                nxt.timer   = '0;
            end else begin
                if (incr && !decr) begin
                    nxt.txn_cnt = entry_q[g].txn_cnt + TxnCntWidth'(1);
                end else if (decr && !incr) begin
                    nxt.txn_cnt = entry_q[g].txn_cnt - TxnCntWidth'(1);
                end
                // A reload wins over the 1->0 step and so suppresses the pulse.
                if (decr) begin
                    nxt.timer = budget_i;
                end else if (!entry_q[g].free && (entry_q[g].timer != '0)) begin
                    nxt.timer = entry_q[g].timer - CntWidth'(1);
                    to_nxt    = (entry_q[g].timer == CntWidth'(1));
                end
            end
        end

        assign entry_d[g]   = nxt;
        assign timeout_d[g] = to_nxt;
    end

    // Table and pulse registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(IdCapacity); i++) begin
                entry_q[i] <= entry_reset();
            end
            timeout_q    <= '0;
            unexpected_q <= 1'b0;
        end else begin
            entry_q      <= entry_d;
            timeout_q    <= timeout_d;
            unexpected_q <= unexpected_d;
        end
    end

endmodule

// File: doc/id_track_alloc.md
# id_track_alloc

Allocator and retirement engine for the AXI monitor's per-ID tracking table. On each accepted request (AW or AR handshake) it either joins an already-tracked ID entry or claims the lowest-index free entry. On each last-beat response it retires one transaction, and it frees the entry when that entry's outstanding count reaches zero. Each busy entry runs a budget timer that raises a timeout pulse on expiry. The block owns the table state that downstream free-vector and timeout logic consume.

## Interface
- `IdCapacity`, 16: number of table entries; must be ≥ 2.
- `IdWidth`, 4: AXI ID width.
- `MaxTxnPerId`, 8: maximum outstanding transactions per entry; the count field width is $clog2(MaxTxnPerId+1).
- `CntWidth`, 10: timer and budget width.
- `id_track_t`, logic: entry struct type with fields `free`, `id`, `txn_cnt`, `timer`.

- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `req_valid_i`  in  1  request-handshake valid.
- `req_ready_o`  out  1  request-handshake ready.
- `req_id_i`  in  IdWidth  ID of the request.
- `rsp_valid_i`  in  1  response beat valid.
- `rsp_ready_o`  out  1  response beat ready; tied to 1.
- `rsp_id_i`  in  IdWidth  ID of the response.
- `rsp_last_i`  in  1  last beat of the response.
- `budget_i`  in  CntWidth  timeout budget in cycles; a value of 0 disables the timer.
- `id_track_o`  out  IdCapacity x id_track_t  registered table state.
- `id_free_o`  out  IdCapacity  per-entry free bits.
- `full_o`  out  1  no entry is free.
- `empty_o`  out  1  every entry is free.
- `timeout_o`  out  IdCapacity  one-cycle timer-expiry pulse per entry.
- `unexpected_rsp_o`  out  1  one-cycle pulse on a last beat whose ID is not tracked.

## Operation
- **Match:** entry i matches when `!free && id == req_id_i`. At most one entry matches a given ID; this is an invariant.
- **Request path:** `req_ready_o` is combinational from registered state and `req_id_i` only, with no dependency on `req_valid_i`.
  - If a match exists: ready = (`txn_cnt` < MaxTxnPerId). On acceptance, increment `txn_cnt`.
  - If no match exists: ready = !`full_o`. On acceptance, claim the lowest-index free entry with `free`=0, `id`=req_id_i, `txn_cnt`=1, `timer`=budget_i.
- **Response path:** only beats with `rsp_valid_i && rsp_last_i` act; all other beats are ignored.
  - If the ID matches and `txn_cnt` > 1: decrement `txn_cnt` and reload `timer` with budget_i.
  - If the ID matches and `txn_cnt` == 1: set `free`=1, `txn_cnt`=0, `timer`=0.
  - If no entry matches: pulse `unexpected_rsp_o`; the table is unchanged.
- **Simultaneous request and response on the same matched entry:** the increment and decrement cancel. `txn_cnt` is unchanged, the entry stays busy even when `txn_cnt` was 1, and `timer` reloads.
- **Simultaneous events on different entries:** both apply independently.
- **Freed entry in the same cycle:** an entry freed this cycle cannot be claimed until the next cycle. Allocation uses the registered free vector.
- **Timer:**
  - While the entry is busy and `timer` > 0, decrement `timer` by 1 each cycle.
  - On the 1→0 transition, pulse `timeout_o[i]` for one cycle.
  - The timer then holds at 0 and does not pulse again until it is reloaded. The entry stays busy; freeing the entry is the response path's job.
  - A reload in the same cycle as the 1→0 transition takes precedence and suppresses the pulse.
- **Budget of 0:** the timer never arms and `timeout_o[i]` never pulses.

## Timing
- After reset, state is:
  - all entries `free`=1, `id`=0, `txn_cnt`=0, `timer`=0;
  - `id_free_o`=all ones, `full_o`=0, `empty_o`=1;
  - `timeout_o`=0, `unexpected_rsp_o`=0, `req_ready_o`=1, `rsp_ready_o`=1.
- `id_free_o`, `full_o` and `empty_o` are combinational from registered state. An allocation or free becomes visible one cycle after the handshake.
- `timeout_o` and `unexpected_rsp_o` are registered. They assert in the cycle after the triggering edge and last exactly one cycle.
- Reset asserted mid-operation clears all outstanding state on the next edge. No pulses are generated by the reset.

## Structure
- Package `id_track_pkg` holds:
  - the field-width helper localparams;
  - the `id_track_t` struct shape: `free`, `id[IdWidth]`, `txn_cnt`, `timer[CntWidth]`.
  - The parent instantiates the concrete type and passes it down as the `id_track_t` parameter.
- Sub-modules:
  - `id_free` produces `id_free_o` from `id_track_o`.
  - `lzc` (common_cells), in trailing-zero mode, selects the lowest free index.
- Per-entry next-state logic lives in a generate loop.

## Test plan
- Reset, then request ID 3 with budget 20 → entry 0 holds `id`=3 and `txn_cnt`=1. `id_free_o`=16'hFFFE. A last-beat response with ID 3 frees the entry on the next edge.
- Issue 16 requests with distinct IDs → `full_o`=1. A 17th request with a new ID sees `req_ready_o`=0. A 17th request reusing ID 5 is accepted and that entry's `txn_cnt` becomes 2.
- Issue 8 requests with ID 7 → `txn_cnt`=8 and the 9th request stalls. One last-beat response drops `txn_cnt` to 7, and ready returns the cycle after.
- Same-cycle request and last-beat response on ID 2 with `txn_cnt`=1 → the entry stays busy, `txn_cnt` stays 1, and `timer` reloads to the budget.
- Budget 4 with no response → exactly one `timeout_o[0]` pulse, 5 cycles after acceptance, and no further pulses. With budget 0, no pulse ever occurs.
- A last-beat response for untracked ID 9 → a single `unexpected_rsp_o` pulse and the table is unchanged. Asserting reset mid-traffic → all reset values hold on the next cycle.
